// File: rtl/bist_pattern_misr.sv
// LFSR pattern source and 16-bit MISR response compactor for netlist self-test.
// Optional golden-signature comparator enabled by defining BIST_GOLDEN_CMP_EN.
module bist_pattern_misr #(
  parameter int IN_W   = 14,
  parameter int OUT_W  = 8,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      seed,
  input  logic [CNT_W-1:0] pat_count,
  output logic [IN_W-1:0]  stim_o,
  input  logic [OUT_W-1:0] resp_i,
`ifdef BIST_GOLDEN_CMP_EN
  input  logic [15:0]      golden_i,
  output logic             pass_o,
`endif
  output logic             busy,
  output logic             done,
  output logic [15:0]      signature
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam int HOLD_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SETTLE - 1);
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
  localparam logic [15:0] MISR_POLY    = 16'h1021;

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [15:0]      misr_q, misr_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic             capture;
  logic             launch;

  assign launch  = (state_q == S_IDLE) && start;
  assign capture = (state_q == S_RUN) && (hold_q == HOLD_LAST);

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= '0;
      misr_q      <= '0;
      remaining_q <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      misr_q      <= misr_d;
      remaining_q <= remaining_d;
      hold_q      <= hold_d;
    end
  end

  // NOTE: defaulting every always_comb output first prevents latch inference.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = (pat_count != '0) ? S_RUN : S_DONE;
      S_RUN:  if (capture && (remaining_q == CNT_W'(1))) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lfsr_d      = lfsr_q;
    misr_d      = misr_q;
    remaining_d = remaining_q;
    hold_d      = hold_q;
    if (launch) begin
      lfsr_d      = (seed == 16'h0000) ? SEED_DEFAULT : seed;
      misr_d      = '0;
      remaining_d = pat_count;
      hold_d      = '0;
    end else if (state_q == S_RUN) begin
      if (!capture) begin
        hold_d = hold_q + HOLD_W'(1);
      end else begin
        misr_d      = ({misr_q[14:0], 1'b0} ^ (misr_q[15] ? MISR_POLY : 16'h0000))
                      ^ 16'(resp_i);
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        remaining_d = remaining_q - CNT_W'(1);
        hold_d      = '0;
      end
    end
  end

`ifdef BIST_GOLDEN_CMP_EN
  logic pass_q, pass_d;

  // Compare against the signature being written on the same edge DONE is entered.
  always_comb begin
    pass_d = pass_q;
    if (launch) pass_d = 1'b0;
    if ((state_d == S_DONE) && (state_q != S_DONE)) pass_d = (misr_d == golden_i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pass_q <= 1'b0;
    else        pass_q <= pass_d;
  end

  assign pass_o = pass_q;
`endif

  always_comb begin
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    stim_o    = lfsr_q[IN_W-1:0];
    signature = misr_q;
  end

endmodule
